// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the bit-serial arithmetic blocks.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Beat counter width; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_addsub_n_if.sv
// Port bundle for serial_addsub_n: operation control, serial operands and results.
interface serial_addsub_n_if
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
);
  // Handshake: start is taken only when the block is idle or in its done cycle;
  // while busy, a_bit/b_bit are consumed on every clock where in_valid is high
  // (there is no ready, the block always accepts in RUN); sum_valid marks each
  // registered sum_bit one cycle later; done pulses once when res/cout/ovf are final.
  logic             start;
  logic             sub;
  logic             in_valid;
  logic             a_bit;
  logic             b_bit;
  logic             busy;
  logic             sum_valid;
  logic             sum_bit;
  logic             done;
  logic [WIDTH-1:0] res;
  logic             cout;
  logic             ovf;
  state_t           dbg_state;

  modport master (
    output start, sub, in_valid, a_bit, b_bit,
    input  busy, sum_valid, sum_bit, done, res, cout, ovf, dbg_state
  );

  modport slave (
    input  start, sub, in_valid, a_bit, b_bit,
    output busy, sum_valid, sum_bit, done, res, cout, ovf, dbg_state
  );

endinterface

// File: rtl/serial_fa_cell.sv
// One-bit full adder with its carry flop; the carry is preset at operation start.
module serial_fa_cell (
  input  logic clk,
  input  logic rst,
  input  logic init,
  input  logic init_val,
  input  logic en,
  input  logic a,
  input  logic b,
  output logic s,
  output logic c_in_q,
  output logic c_out
);

  logic carry_q;

  assign s      = a ^ b ^ carry_q;
  assign c_out  = (a & b) | (a & carry_q) | (b & carry_q);
  assign c_in_q = carry_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      carry_q <= 1'b0;
    end else if (init) begin
      carry_q <= init_val;
    end else if (en) begin
      carry_q <= c_out;
    end
  end

endmodule

// File: rtl/serial_addsub_n.sv
// Bit-serial WIDTH-bit adder/subtractor: LSB-first operands, serial and parallel result,
// unsigned carry/no-borrow and signed overflow flags.
module serial_addsub_n
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst,
  serial_addsub_n_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state_q, state_d;
  logic             sub_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] res_q;
  logic             cout_q, ovf_q;
  logic             sum_valid_q, sum_bit_q;
  logic             start_ok, beat, last_beat;
  logic             fa_s, fa_cin, fa_cout;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    start_ok  = 1'b0;
    beat      = 1'b0;
    last_beat = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          start_ok = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (bus.in_valid) begin
          beat = 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            last_beat = 1'b1;
            state_d   = DONE;
          end
        end
      end
      DONE: begin
        if (bus.start) begin
          start_ok = 1'b1;
          state_d  = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Subtract is a + ~b + 1: invert b per beat and preset the carry to 1.
  serial_fa_cell u_fa (
    .clk      (clk),
    .rst      (rst),
    .init     (start_ok),
    .init_val (bus.sub == MODE_SUB),
    .en       (beat),
    .a        (bus.a_bit),
    .b        (bus.b_bit ^ sub_q),
    .s        (fa_s),
    .c_in_q   (fa_cin),
    .c_out    (fa_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      sub_q       <= MODE_ADD;
      cnt_q       <= '0;
      res_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      sum_valid_q <= 1'b0;
      sum_bit_q   <= 1'b0;
    end else begin
      sum_valid_q <= beat;
      if (start_ok) begin
        sub_q  <= bus.sub;
        cnt_q  <= '0;
        cout_q <= 1'b0;
        ovf_q  <= 1'b0;
      end
      if (beat) begin
        sum_bit_q <= fa_s;
        res_q     <= {fa_s, res_q[WIDTH-1:1]};
        cnt_q     <= cnt_q + CW'(1);
      end
      // Signed overflow: carry into the sign bit differs from carry out of it.
      if (last_beat) begin
        cout_q <= fa_cout;
        ovf_q  <= fa_cin ^ fa_cout;
      end
    end
  end

  assign bus.busy      = (state_q == RUN);
  assign bus.done      = (state_q == DONE);
  assign bus.sum_valid = sum_valid_q;
  assign bus.sum_bit   = sum_bit_q;
  assign bus.res       = res_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_serial_addsub_n.sv
// Bench for serial_addsub_n at WIDTH 8, 2 and 16: directed vector table, corner
// sequences and random operations against an arithmetic reference model.
module tb_serial_addsub_n;
  import serial_arith_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic start_r, sub_r, inv_r, a_r, b_r;
  int   sel;

  serial_addsub_n_if #(.WIDTH(8))  if8 ();
  serial_addsub_n_if #(.WIDTH(2))  if2 ();
  serial_addsub_n_if #(.WIDTH(16)) if16 ();

  serial_addsub_n #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(if8));
  serial_addsub_n #(.WIDTH(2))  u_dut2  (.clk(clk), .rst(rst), .bus(if2));
  serial_addsub_n #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .bus(if16));

  assign if8.start  = start_r & (sel == 0);
  assign if2.start  = start_r & (sel == 1);
  assign if16.start = start_r & (sel == 2);
  assign if8.sub = sub_r;      assign if2.sub = sub_r;      assign if16.sub = sub_r;
  assign if8.in_valid = inv_r; assign if2.in_valid = inv_r; assign if16.in_valid = inv_r;
  assign if8.a_bit = a_r;      assign if2.a_bit = a_r;      assign if16.a_bit = a_r;
  assign if8.b_bit = b_r;      assign if2.b_bit = b_r;      assign if16.b_bit = b_r;

  logic        o_busy, o_sv, o_sb, o_done, o_cout, o_ovf;
  logic [63:0] o_res;
  state_t      o_state;

  always_comb begin
    o_busy = if8.busy; o_sv = if8.sum_valid; o_sb = if8.sum_bit; o_done = if8.done;
    o_cout = if8.cout; o_ovf = if8.ovf; o_res = 64'(if8.res); o_state = if8.dbg_state;
    if (sel == 1) begin
      o_busy = if2.busy; o_sv = if2.sum_valid; o_sb = if2.sum_bit; o_done = if2.done;
      o_cout = if2.cout; o_ovf = if2.ovf; o_res = 64'(if2.res); o_state = if2.dbg_state;
    end else if (sel == 2) begin
      o_busy = if16.busy; o_sv = if16.sum_valid; o_sb = if16.sum_bit; o_done = if16.done;
      o_cout = if16.cout; o_ovf = if16.ovf; o_res = 64'(if16.res); o_state = if16.dbg_state;
    end
  end

  int checks = 0;
  int errors = 0;
  logic [0:0] exp_q[$];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  function automatic int wid(input int s);
    return (s == 1) ? 2 : (s == 2) ? 16 : 8;
  endfunction

  // Reference: plain integer arithmetic on the operands.
  function automatic void model(input int w, input logic [63:0] a, input logic [63:0] b,
                                input logic s, output logic [63:0] r,
                                output logic co, output logic ov);
    longint mask, half, ua, ub, sa, sb, t;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua = longint'(a) & mask;
    ub = longint'(b) & mask;
    sa = (ua >= half) ? ua - (longint'(1) << w) : ua;
    sb = (ub >= half) ? ub - (longint'(1) << w) : ub;
    if (s == MODE_SUB) begin
      r  = 64'((ua - ub) & mask);
      co = (ua >= ub);
      t  = sa - sb;
    end else begin
      r  = 64'((ua + ub) & mask);
      co = (((ua + ub) >> w) & 1) != 0;
      t  = sa + sb;
    end
    ov = (t < -half) || (t >= half);
  endfunction

  always @(negedge clk) begin
    if (o_sv === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("sum_valid_unexpected", 64'(o_sv), 64'(0));
      end else begin
        chk("sum_bit", 64'(o_sb), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic do_start(input logic s);
    start_r = 1'b1;
    sub_r   = s;
    @(posedge clk); #1;
    start_r = 1'b0;
    chk("start_busy", 64'(o_busy), 64'(1));
    chk("start_cout_clr", 64'(o_cout), 64'(0));
    chk("start_ovf_clr", 64'(o_ovf), 64'(0));
  endtask

  task automatic do_beats(input int w, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] stall, input int start_at,
                          input logic [63:0] exp_res);
    for (int k = 0; k < w; k++) begin
      exp_q.push_back(exp_res[k]);
      if (stall[k]) begin
        inv_r = 1'b0;
        a_r   = 1'($urandom);
        b_r   = 1'($urandom);
        @(posedge clk); #1;
        chk("stall_sum_valid", 64'(o_sv), 64'(0));
      end
      if (k == w - 1) begin
        chk("pre_last_done", 64'(o_done), 64'(0));
        chk("pre_last_busy", 64'(o_busy), 64'(1));
      end
      inv_r   = 1'b1;
      a_r     = a[k];
      b_r     = b[k];
      start_r = (k == start_at);
      @(posedge clk); #1;
      start_r = 1'b0;
      inv_r   = 1'b0;
    end
  endtask

  task automatic check_result(input string nm, input logic [63:0] r,
                              input logic co, input logic ov);
    chk({nm, "_done"}, 64'(o_done), 64'(1));
    chk({nm, "_busy"}, 64'(o_busy), 64'(0));
    chk({nm, "_res"},  o_res, r);
    chk({nm, "_cout"}, 64'(o_cout), 64'(co));
    chk({nm, "_ovf"},  64'(o_ovf), 64'(ov));
  endtask

  task automatic idle_hold(input logic [63:0] r, input logic co, input logic ov);
    @(posedge clk); #1;
    chk("idle_done", 64'(o_done), 64'(0));
    chk("idle_state", 64'(o_state), 64'(IDLE));
    chk("hold_res", o_res, r);
    chk("hold_cout", 64'(o_cout), 64'(co));
    chk("hold_ovf", 64'(o_ovf), 64'(ov));
  endtask

  typedef struct {
    int          sel;
    logic        sub;
    logic [63:0] a, b, stall, res;
    logic        cout, ovf;
  } vec_t;

  vec_t tbl[13];

  initial begin
    logic [63:0] ra, rb, rst_mask, rr;
    logic        rco, rov, rs;
    int          w;

    tbl[0]  = '{0, MODE_ADD, 64'h35,   64'h4A,   64'h0,  64'h7F,   1'b0, 1'b0};
    tbl[1]  = '{0, MODE_ADD, 64'h7F,   64'h01,   64'h0,  64'h80,   1'b0, 1'b1};
    tbl[2]  = '{0, MODE_ADD, 64'hFF,   64'h01,   64'h0,  64'h00,   1'b1, 1'b0};
    tbl[3]  = '{0, MODE_SUB, 64'h10,   64'h20,   64'h0,  64'hF0,   1'b0, 1'b0};
    tbl[4]  = '{0, MODE_SUB, 64'h80,   64'h01,   64'h0,  64'h7F,   1'b1, 1'b1};
    tbl[5]  = '{0, MODE_SUB, 64'h05,   64'h05,   64'h0,  64'h00,   1'b1, 1'b0};
    tbl[6]  = '{0, MODE_ADD, 64'h35,   64'h4A,   64'h26, 64'h7F,   1'b0, 1'b0};
    tbl[7]  = '{1, MODE_ADD, 64'h1,    64'h2,    64'h0,  64'h3,    1'b0, 1'b0};
    tbl[8]  = '{1, MODE_ADD, 64'h1,    64'h1,    64'h0,  64'h2,    1'b0, 1'b1};
    tbl[9]  = '{1, MODE_ADD, 64'h2,    64'h3,    64'h0,  64'h1,    1'b1, 1'b1};
    tbl[10] = '{2, MODE_ADD, 64'h35,   64'h4A,   64'h0,  64'h7F,   1'b0, 1'b0};
    tbl[11] = '{2, MODE_ADD, 64'h8000, 64'h8000, 64'h0,  64'h0,    1'b1, 1'b1};
    tbl[12] = '{2, MODE_SUB, 64'h1234, 64'h4321, 64'h0,  64'hCF13, 1'b0, 1'b0};

    sel = 0; rst = 1'b1; start_r = 1'b1; sub_r = 1'b1; inv_r = 1'b1; a_r = 1'b1; b_r = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 64'(o_state), 64'(IDLE));
    chk("rst_busy", 64'(o_busy), 64'(0));
    chk("rst_done", 64'(o_done), 64'(0));
    chk("rst_sum_valid", 64'(o_sv), 64'(0));
    chk("rst_res", o_res, 64'(0));
    chk("rst_cout", 64'(o_cout), 64'(0));
    chk("rst_ovf", 64'(o_ovf), 64'(0));
    rst = 1'b0; start_r = 1'b0; inv_r = 1'b0;

    // in_valid while idle must not produce a beat.
    inv_r = 1'b1;
    @(posedge clk); #1;
    inv_r = 1'b0;
    chk("idle_in_valid_busy", 64'(o_busy), 64'(0));
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      sel = tbl[i].sel;
      w   = wid(sel);
      do_start(tbl[i].sub);
      do_beats(w, tbl[i].a, tbl[i].b, tbl[i].stall, -1, tbl[i].res);
      check_result($sformatf("vec%0d", i), tbl[i].res, tbl[i].cout, tbl[i].ovf);
      idle_hold(tbl[i].res, tbl[i].cout, tbl[i].ovf);
    end

    // start pulsed mid-RUN is ignored.
    sel = 0;
    do_start(MODE_ADD);
    do_beats(8, 64'h35, 64'h4A, 64'h0, 3, 64'h7F);
    check_result("mid_start", 64'h7F, 1'b0, 1'b0);
    idle_hold(64'h7F, 1'b0, 1'b0);

    // Reset after three beats aborts the operation without a done pulse.
    do_start(MODE_ADD);
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(1'b1);
      inv_r = 1'b1; a_r = 1'b1; b_r = 1'b0;
      @(posedge clk); #1;
    end
    rst = 1'b1; start_r = 1'b1; inv_r = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start_r = 1'b0; inv_r = 1'b0;
    chk("abort_busy", 64'(o_busy), 64'(0));
    chk("abort_res", o_res, 64'(0));
    chk("abort_done", 64'(o_done), 64'(0));
    chk("abort_sum_valid", 64'(o_sv), 64'(0));
    chk("abort_cout", 64'(o_cout), 64'(0));
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("abort_no_done", 64'(o_done), 64'(0));
    end
    do_start(MODE_ADD);
    do_beats(8, 64'h12, 64'h34, 64'h0, -1, 64'h46);
    check_result("after_abort", 64'h46, 1'b0, 1'b0);

    // Back-to-back: second start issued in the DONE cycle.
    @(posedge clk); #1;
    do_start(MODE_ADD);
    do_beats(8, 64'h7F, 64'h01, 64'h0, -1, 64'h80);
    check_result("b2b_first", 64'h80, 1'b0, 1'b1);
    do_start(MODE_SUB);
    do_beats(8, 64'h20, 64'h01, 64'h0, -1, 64'h1F);
    check_result("b2b_second", 64'h1F, 1'b1, 1'b0);
    idle_hold(64'h1F, 1'b1, 1'b0);

    for (int n = 0; n < 24; n++) begin
      sel = $urandom_range(0, 2);
      w   = wid(sel);
      ra  = {$urandom, $urandom};
      rb  = {$urandom, $urandom};
      rs  = 1'($urandom_range(0, 1));
      rst_mask = '0;
      for (int k = 0; k < w; k++) rst_mask[k] = ($urandom_range(0, 3) == 0);
      model(w, ra, rb, rs, rr, rco, rov);
      do_start(rs);
      do_beats(w, ra, rb, rst_mask, -1, rr);
      check_result($sformatf("rand%0d", n), rr, rco, rov);
      if ($urandom_range(0, 1) == 1) idle_hold(rr, rco, rov);
      else begin @(posedge clk); #1; end
    end

    @(posedge clk); #1;
    chk("stream_drained", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
